line_cache_responder: RTL



---
 rtl/line_cache_responder_if.sv | 33 +++
 rtl/line_cache_responder.sv | 84 ++++++++
 2 files changed

// File: rtl/line_cache_responder_if.sv
// Dual-read / single-write line bus between the cache driver (master)
// and the line cache responder (slave).
interface line_cache_responder_if #(
    parameter int ADDR_LENTH = 32,
    parameter int LINE_SIZE  = 128
);
    logic                  re_p1_i;
    logic [ADDR_LENTH-1:0] raddr_p1_i;
    logic [LINE_SIZE-1:0]  rdata_p1_o;
    logic                  read_hit_p1_o;

    logic                  re_p2_i;
    logic [ADDR_LENTH-1:0] raddr_p2_i;
    logic [LINE_SIZE-1:0]  rdata_p2_o;
    logic                  read_hit_p2_o;

    logic                  we_p1_i;
    logic [ADDR_LENTH-1:0] waddr_p1_i;
    logic [LINE_SIZE-1:0]  wdata_p1_i;
    logic                  write_hit_p1_o;

    modport master (
        output re_p1_i, raddr_p1_i, re_p2_i, raddr_p2_i,
        output we_p1_i, waddr_p1_i, wdata_p1_i,
        input  rdata_p1_o, read_hit_p1_o, rdata_p2_o, read_hit_p2_o, write_hit_p1_o
    );

    modport slave (
        input  re_p1_i, raddr_p1_i, re_p2_i, raddr_p2_i,
        input  we_p1_i, waddr_p1_i, wdata_p1_i,
        output rdata_p1_o, read_hit_p1_o, rdata_p2_o, read_hit_p2_o, write_hit_p1_o
    );
endinterface

// File: rtl/line_cache_responder.sv
// Direct-mapped line store with two independent read ports and one
// write-allocate port; all responses registered one cycle after the request.
module line_cache_responder #(
    parameter int ADDR_LENTH  = 32,
    parameter int LINE_SIZE   = 128,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    line_cache_responder_if.slave bus
);
    localparam int TAG_BITS = ADDR_LENTH - INDEX_BITS - OFFSET_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int RPORTS   = 2;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [LINE_SIZE-1:0]  line_t;

    logic [ENTRIES-1:0] valid_q, valid_d;
    tag_t               tag_q  [ENTRIES];
    line_t              line_q [ENTRIES];

    logic [RPORTS-1:0]                 re;
    logic [RPORTS-1:0][ADDR_LENTH-1:0] raddr;
    logic [RPORTS-1:0][LINE_SIZE-1:0]  rdata_q, rdata_d;
    logic [RPORTS-1:0]                 rhit_q, rhit_d;
    logic                              whit_q, whit_d;

    assign re    = {bus.re_p2_i, bus.re_p1_i};
    assign raddr = {bus.raddr_p2_i, bus.raddr_p1_i};

    // Reads look up pre-write state: no bypass from a same-cycle write.
    for (genvar p = 0; p < RPORTS; p++) begin : g_rd
        idx_t ridx;
        tag_t rtag;
        logic hit;
        assign ridx       = idx_t'(raddr[p] >> OFFSET_BITS);
        assign rtag       = tag_t'(raddr[p] >> (OFFSET_BITS + INDEX_BITS));
        assign hit        = valid_q[ridx] && (tag_q[ridx] == rtag);
        assign rhit_d[p]  = re[p] && hit;
        assign rdata_d[p] = !re[p] ? rdata_q[p] : (hit ? line_q[ridx] : '0);
    end

    idx_t widx;
    tag_t wtag;
    assign widx   = idx_t'(bus.waddr_p1_i >> OFFSET_BITS);
    assign wtag   = tag_t'(bus.waddr_p1_i >> (OFFSET_BITS + INDEX_BITS));
    assign whit_d = bus.we_p1_i && valid_q[widx] && (tag_q[widx] == wtag);

    always_comb begin
        valid_d = valid_q;
        if (bus.we_p1_i) valid_d[widx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rdata_q <= '0;
            rhit_q  <= '0;
            whit_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            rhit_q  <= rhit_d;
            whit_q  <= whit_d;
        end
    end

    // Tag/data arrays are not reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (!rst && bus.we_p1_i) begin
            tag_q[widx]  <= wtag;
            line_q[widx] <= bus.wdata_p1_i;
        end
    end

    assign bus.rdata_p1_o     = rdata_q[0];
    assign bus.read_hit_p1_o  = rhit_q[0];
    assign bus.rdata_p2_o     = rdata_q[1];
    assign bus.read_hit_p2_o  = rhit_q[1];
    assign bus.write_hit_p1_o = whit_q;
endmodule
